// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, word type and FSM state encoding.
package aes_pkg;

   localparam int unsigned AES_NK = 4;
   localparam int unsigned AES_NR = 10;
   localparam logic [3:0]  LAST_ROUND = 4'(AES_NR);
   localparam logic [3:0]  RCON_LAST  = 4'd9;

   typedef logic [31:0] aes_word_t;

   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic [1:0] {
      StIdle,
      StExpand,
      StEmit
   } keyexp_state_t;

   function automatic aes_word_t rot_word(aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_key_expand_128_if.sv
// Key-load / round-key stream bundle for the AES-128 key-schedule engine.
interface aes_key_expand_128_if;

   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         done;

   modport master (
      output start, key, rk_ready,
      input  busy, rk_valid, rk, rk_round, done
   );

   modport slave (
      input  start, key, rk_ready,
      output busy, rk_valid, rk, rk_round, done
   );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule emitting round keys 0..10 over a valid/ready stream.
// Define AES_KEYEXP_REVERSE_EN to pre-expand into a buffer and emit keys 10..0 instead.
module aes_key_expand_128
   import aes_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   aes_key_expand_128_if.slave bus
);

   keyexp_state_t state;
   logic [127:0]  rk_q;
   logic [3:0]    round;
   logic [3:0]    rcon_idx;
   logic          rk_valid_q;
   logic          busy_q;
   logic          done_q;

   logic [127:0]  work_key;
   logic [127:0]  next_key;
   aes_word_t     w0, w1, w2, w3, w4, w5, w6, w7;
   aes_word_t     rot, sub_word, t;
   logic [3:0]    rcon_sel;
   logic          handshake;

`ifdef AES_KEYEXP_REVERSE_EN
   logic [127:0]  cur_key;
   logic [127:0]  key_buf [AES_NR+1];

   assign work_key = cur_key;
`else
   // Forward order expands straight from the key currently on the output.
   assign work_key = rk_q;
`endif

   assign {w0, w1, w2, w3} = work_key;
   assign rot = rot_word(w3);

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .data (rot[8*i +: 8]),
         .sub  (sub_word[8*i +: 8])
      );
   end

   assign rcon_sel = (rcon_idx > RCON_LAST) ? RCON_LAST : rcon_idx;
   assign t        = sub_word ^ {RCON[rcon_sel], 24'h0};
   assign w4       = w0 ^ t;
   assign w5       = w1 ^ w4;
   assign w6       = w2 ^ w5;
   assign w7       = w3 ^ w6;
   assign next_key = {w4, w5, w6, w7};

   assign handshake = rk_valid_q & bus.rk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         rk_q       <= '0;
         round      <= '0;
         rcon_idx   <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
         cur_key    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state)
            StIdle: begin
               if (bus.start) begin
                  round    <= '0;
                  rcon_idx <= '0;
                  busy_q   <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
                  cur_key  <= bus.key;
                  state    <= StExpand;
`else
                  rk_q       <= bus.key;
                  rk_valid_q <= 1'b1;
                  state      <= StEmit;
`endif
               end
            end
`ifdef AES_KEYEXP_REVERSE_EN
            StExpand: begin
               cur_key <= next_key;
               if (round != LAST_ROUND) round <= round + 4'd1;
               if (rcon_idx != LAST_ROUND) rcon_idx <= rcon_idx + 4'd1;
               // Last expansion step: key 10 goes straight to the output.
               if (round == LAST_ROUND - 4'd1) begin
                  rk_q       <= next_key;
                  rk_valid_q <= 1'b1;
                  state      <= StEmit;
               end
            end
`endif
            StEmit: begin
               if (handshake) begin
`ifdef AES_KEYEXP_REVERSE_EN
                  if (round == 4'd0) begin
                     state      <= StIdle;
                     rk_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     rk_q  <= key_buf[round - 4'd1];
                     round <= round - 4'd1;
                  end
`else
                  if (round == LAST_ROUND) begin
                     state      <= StIdle;
                     rk_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     rk_q  <= next_key;
                     round <= round + 4'd1;
                     if (rcon_idx != LAST_ROUND) rcon_idx <= rcon_idx + 4'd1;
                  end
`endif
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef AES_KEYEXP_REVERSE_EN
   always_ff @(posedge clk) begin
      if (state == StIdle && bus.start) begin
         key_buf[0] <= bus.key;
      end else if (state == StExpand) begin
         key_buf[round + 4'd1] <= next_key;
      end
   end
`endif

   assign bus.busy     = busy_q;
   assign bus.rk_valid = rk_valid_q;
   assign bus.rk       = rk_q;
   assign bus.rk_round = round;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128: independent GF(2^8) model feeding a scoreboard.
`timescale 1ns/1ps
module tb_aes_key_expand_128;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_key_expand_128_if bus ();

   aes_key_expand_128 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef AES_KEYEXP_REVERSE_EN
   localparam int FIRST_CYC = 11;
`else
   localparam int FIRST_CYC = 1;
`endif
   localparam int DONE_CYC = FIRST_CYC + 11;

   typedef struct {
      logic [127:0] rk;
      logic [3:0]   round;
   } exp_t;

   typedef struct {
      logic [127:0] key;
      logic [127:0] r1;
      logic [127:0] r10;
   } vec_t;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   exp_t         sb_q [$];
   logic [127:0] ref_ks [11];
   logic [127:0] captured [11];
   int           last_first, last_done, last_hs;
   bit           aborted;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] xtime(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   function automatic logic [7:0] sbox_ref(logic [7:0] v);
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])}
                ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ref_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_expected(input logic [127:0] key);
      exp_t e;
      model_expand(key);
      for (int k = 0; k < 11; k++) begin
`ifdef AES_KEYEXP_REVERSE_EN
         e.round = 4'(10 - k);
`else
         e.round = 4'(k);
`endif
         e.rk = ref_ks[e.round];
         sb_q.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_key(input logic [127:0] key);
      push_expected(key);
      bus.key   = key;
      bus.start = 1'b1;
      cyc       = 0;
      step();
      bus.start = 1'b0;
      check("busy after start", bus.busy, 1'b1);
      check("first valid latency", bus.rk_valid, (FIRST_CYC == 1) ? 1'b1 : 1'b0);
   endtask

   task automatic run_stream(input bit rand_ready, input int abort_round, input int busy_round,
                             input bit final_start);
      int           budget     = 400;
      bit           prev_stall = 1'b0;
      bit           busy_hit   = 1'b0;
      bit           fin        = 1'b0;
      bit           last_hs_now;
      int           early_done = 0;
      logic [127:0] prev_rk    = '0;
      logic [3:0]   prev_round = '0;
      exp_t         e;
      last_first = -1;
      last_done  = -1;
      last_hs    = 0;
      aborted    = 1'b0;
      while (!fin && budget > 0) begin
         budget--;
         bus.start    = 1'b0;
         bus.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         last_hs_now  = 1'b0;
         if (bus.done) early_done++;
         if (prev_stall) begin
            check("stall keeps valid", bus.rk_valid, 1'b1);
            check("stall holds rk", bus.rk, prev_rk);
            check("stall holds round", bus.rk_round, prev_round);
         end
         if (bus.rk_valid && last_first < 0) last_first = cyc;
         if (bus.rk_valid && abort_round >= 0 && int'(bus.rk_round) == abort_round) begin
            rst          = 1'b1;
            bus.rk_ready = 1'b0;
            step();
            rst = 1'b0;
            check("abort rk_valid", bus.rk_valid, 1'b0);
            check("abort busy", bus.busy, 1'b0);
            check("abort rk", bus.rk, 128'h0);
            check("abort rk_round", bus.rk_round, 4'd0);
            check("abort done", bus.done, 1'b0);
            step();
            check("no done after abort", bus.done, 1'b0);
            sb_q.delete();
            aborted = 1'b1;
            return;
         end
         if (bus.rk_valid && busy_round >= 0 && !busy_hit && int'(bus.rk_round) == busy_round) begin
            bus.start = 1'b1;
            bus.key   = '0;
            busy_hit  = 1'b1;
         end
         if (bus.rk_valid && bus.rk_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected extra key", bus.rk_round, 4'hf);
            end else begin
               e = sb_q.pop_front();
               check("round key", bus.rk, e.rk);
               check("round index", bus.rk_round, e.round);
               captured[bus.rk_round] = bus.rk;
               last_hs++;
               if (sb_q.size() == 0) begin
                  last_hs_now = 1'b1;
                  if (final_start) begin
                     bus.start = 1'b1;
                     bus.key   = '0;
                  end
               end
            end
         end
         prev_stall = bus.rk_valid && !bus.rk_ready;
         prev_rk    = bus.rk;
         prev_round = bus.rk_round;
         step();
         if (last_hs_now) begin
            last_done = cyc;
            check("done pulse", bus.done, 1'b1);
            check("busy low at done", bus.busy, 1'b0);
            check("valid low at done", bus.rk_valid, 1'b0);
            if (final_start) begin
               // Start in the done cycle must be taken.
               push_expected('0);
               bus.key   = '0;
               bus.start = 1'b1;
               cyc       = 0;
               step();
               bus.start = 1'b0;
               check("start in done cycle", bus.busy, 1'b1);
               check("single done", bus.done, 1'b0);
            end else begin
               bus.start = 1'b0;
               step();
               check("done one cycle", bus.done, 1'b0);
               check("idle after done", bus.busy, 1'b0);
            end
            fin = 1'b1;
         end
      end
      check("stream finished in budget", fin, 1'b1);
      check("no early done", early_done, 0);
   endtask

   vec_t vecs [2];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0].key = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
      vecs[0].r1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
      vecs[0].r10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
      vecs[1].key = 128'h0;
      vecs[1].r1  = 128'h62636363_62636363_62636363_62636363;
      vecs[1].r10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.key      = '0;
      bus.rk_ready = 1'b0;
      step();
      step();
      check("reset busy", bus.busy, 1'b0);
      check("reset rk_valid", bus.rk_valid, 1'b0);
      check("reset rk", bus.rk, 128'h0);
      check("reset rk_round", bus.rk_round, 4'd0);
      check("reset done", bus.done, 1'b0);
      rst = 1'b0;
      step();

      // Full-rate streams against the known anchor vectors.
      for (int v = 0; v < 2; v++) begin
         start_key(vecs[v].key);
         run_stream(1'b0, -1, -1, 1'b0);
         check("vec round 0", captured[0], vecs[v].key);
         check("vec round 1", captured[1], vecs[v].r1);
         check("vec round 10", captured[10], vecs[v].r10);
         check("first valid cycle", last_first, FIRST_CYC);
         check("done cycle", last_done, DONE_CYC);
         check("key count", last_hs, 11);
      end

      // Random backpressure.
      start_key(vecs[0].key);
      run_stream(1'b1, -1, -1, 1'b0);
      check("bp key count", last_hs, 11);
      check("bp round 10", captured[10], vecs[0].r10);

      // Start while busy is ignored.
      start_key(vecs[0].key);
      run_stream(1'b1, -1, 5, 1'b0);
      check("busy-start key count", last_hs, 11);
      check("busy-start round 10", captured[10], vecs[0].r10);

      // Reset mid-stream, then a fresh start.
      start_key(vecs[0].key);
      run_stream(1'b0, 3, -1, 1'b0);
      check("abort taken", aborted, 1'b1);
      start_key(vecs[0].key);
      run_stream(1'b0, -1, -1, 1'b0);
      check("restart round 0", captured[0], vecs[0].key);

      // Start on final handshake ignored; start in done cycle accepted.
      start_key(vecs[0].key);
      run_stream(1'b0, -1, -1, 1'b1);
      run_stream(1'b0, -1, -1, 1'b0);
      check("chained round 1", captured[1], vecs[1].r1);
      check("chained done cycle", last_done, DONE_CYC);
      check("scoreboard drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
